operand_loader: RTL and testbench

//   Upstream operand-entry stage for the 6-bit ALU function units (equal, add, sub, ...).

---
 rtl/operand_loader.sv | 172 +++++++++++++++++
 tb/tb_operand_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//   Operand-entry stage in front of the 6-bit ALU function units. Operand A,
//   then operand B, then the opcode are taken from the board slide switches.
//   Each one is captured on a debounced press of the load push-button. The
//   captured values are held steady, and operands_valid is raised once all
//   three are loaded. The clear push-button abandons the entry and zeroes the
//   operands.
//
// Parameters
//   WIDTH            operand width, two's complement (MSB is the sign bit)
//   OP_WIDTH         opcode width
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a button level (>=2)
//
// Ports
//   clk             system clock
//   rst_n           asynchronous, active-low reset
//   sw              raw operand slide switches (asynchronous)
//   op_sw           raw opcode slide switches (asynchronous)
//   load_btn        raw load push-button, active-high, bouncy
//   clear_btn       raw clear push-button, active-high, bouncy
//   A, B            captured operands, copied bit-exact (no sign handling)
//   op              captured opcode
//   operands_valid  high only while all three values are loaded (READY)
//   state_led       current state: WAIT_A=0, WAIT_B=1, WAIT_OP=2, READY=3
// -----------------------------------------------------------------------------
module operand_loader #(
  parameter int WIDTH           = 6,
  parameter int OP_WIDTH        = 3,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    sw,
  input  logic [OP_WIDTH-1:0] op_sw,
  input  logic                load_btn,
  input  logic                clear_btn,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    B,
  output logic [OP_WIDTH-1:0] op,
  output logic                operands_valid,
  output logic [1:0]          state_led
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  // The counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index of each button in the packed button vectors below.
  localparam int BTN_LOAD  = 0;
  localparam int BTN_CLEAR = 1;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for every asynchronous board input.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]    sw_s1,    sw_s2;
  logic [OP_WIDTH-1:0] op_sw_s1, op_sw_s2;
  logic [1:0]          btn_s1,   btn_s2;

  // NOTE: Sequential state uses non-blocking assignments only. Every flop
  // samples the value from before the edge, so the two synchronizer stages
  // really are two cycles apart. Blocking assignments here would collapse
  // the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      op_sw_s1 <= '0;
      op_sw_s2 <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
    end else begin
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      op_sw_s1 <= op_sw;
      op_sw_s2 <= op_sw_s1;
      btn_s1   <= {clear_btn, load_btn};
      btn_s2   <= btn_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce, one lane per button. Any cycle where the synchronized level
  // agrees with the accepted level restarts the count. A level must therefore
  // differ for DEBOUNCE_CYCLES consecutive cycles before it is accepted. Only
  // an accepted rising level produces a press pulse. Holding the button gives
  // one pulse, and a release gives none.
  // ---------------------------------------------------------------------------
  logic [1:0]            btn_deb;
  logic [1:0]            btn_press;
  logic [1:0][CNT_W-1:0] btn_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_deb   <= '0;
      btn_press <= '0;
      btn_cnt   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_s2[i] == btn_deb[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == CNT_MAX) begin
          btn_deb[i]   <= btn_s2[i];
          btn_cnt[i]   <= '0;
          btn_press[i] <= btn_s2[i];
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  logic load_pulse;
  logic clear_pulse;

  assign load_pulse  = btn_press[BTN_LOAD];
  assign clear_pulse = btn_press[BTN_CLEAR];

  // ---------------------------------------------------------------------------
  // Entry FSM with registered outputs. Clear has priority over load, so a
  // simultaneous load is discarded. A reload from READY keeps the old
  // operands on display until each one is overwritten.
  // ---------------------------------------------------------------------------
  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_A;
      A              <= '0;
      B              <= '0;
      op             <= '0;
      operands_valid <= 1'b0;
    end else if (clear_pulse) begin
      state          <= WAIT_A;
      A              <= '0;
      B              <= '0;
      op             <= '0;
      operands_valid <= 1'b0;
    end else if (load_pulse) begin
      case (state)
        WAIT_A: begin
          A     <= sw_s2;
          state <= WAIT_B;
        end
        WAIT_B: begin
          B     <= sw_s2;
          state <= WAIT_OP;
        end
        WAIT_OP: begin
          op             <= op_sw_s2;
          operands_valid <= 1'b1;
          state          <= READY;
        end
        default: begin
          operands_valid <= 1'b0;
          state          <= WAIT_A;
        end
      endcase
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_operand_loader
//   Directed bench for operand_loader, built with DEBOUNCE_CYCLES=4. Inputs
//   change 1 time unit after a rising edge, and outputs are sampled at the
//   same point.
//
//   A raw press asserted just after edge 0 is synchronized at edge 2. It
//   counts at edges 3-5 and is accepted as a pulse at edge 6. The FSM acts
//   on that pulse at edge 7. Every press below is held for 8 cycles and
//   released for 8 cycles, which covers both the press and the release.
// -----------------------------------------------------------------------------
module tb_operand_loader;

  localparam int WIDTH    = 6;
  localparam int OP_WIDTH = 3;
  localparam int DEB      = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [WIDTH-1:0]    sw;
  logic [OP_WIDTH-1:0] op_sw;
  logic                load_btn;
  logic                clear_btn;
  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic [OP_WIDTH-1:0] op;
  logic                operands_valid;
  logic [1:0]          state_led;

  int errors = 0;
  int checks = 0;

  operand_loader #(
    .WIDTH          (WIDTH),
    .OP_WIDTH       (OP_WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw            (sw),
    .op_sw         (op_sw),
    .load_btn      (load_btn),
    .clear_btn     (clear_btn),
    .A             (A),
    .B             (B),
    .op            (op),
    .operands_valid(operands_valid),
    .state_led     (state_led)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_load();
    load_btn = 1'b1;
    wait_cycles(8);
    load_btn = 1'b0;
    wait_cycles(8);
  endtask

  task automatic press_clear();
    clear_btn = 1'b1;
    wait_cycles(8);
    clear_btn = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    sw        = '0;
    op_sw     = '0;
    load_btn  = 1'b0;
    clear_btn = 1'b0;
    #12;
    checks++;
    if ({A, B, op, operands_valid, state_led} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got A=%h B=%h op=%0d valid=%b state=%0d, expected all 0",
               A, B, op, operands_valid, state_led);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2);
    checks++;
    if (state_led !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", state_led);
    end
  endtask

  // Full entry of -3, +3 and opcode 2.
  task automatic test_sequence();
    sw = 6'b111101;
    press_load();
    checks++;
    if (A !== 6'h3D || state_led !== 2'd1) begin
      errors++;
      $display("FAIL seq_A: got A=%h state=%0d expected A=3d state=1", A, state_led);
    end
    sw = 6'b000011;
    press_load();
    checks++;
    if (B !== 6'h03 || state_led !== 2'd2 || operands_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_B: got B=%h state=%0d valid=%b expected B=03 state=2 valid=0",
               B, state_led, operands_valid);
    end
    op_sw = 3'd2;
    press_load();
    checks++;
    if (A !== 6'h3D || B !== 6'h03 || op !== 3'd2 || operands_valid !== 1'b1 || state_led !== 2'd3) begin
      errors++;
      $display("FAIL seq_ready: got A=%h B=%h op=%0d valid=%b state=%0d expected 3d 03 2 1 3",
               A, B, op, operands_valid, state_led);
    end
  endtask

  // A level that never stays stable for DEB cycles must be ignored.
  task automatic test_glitch();
    press_clear();
    checks++;
    if (state_led !== 2'd0 || A !== 6'h00 || operands_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_clear: got state=%0d A=%h valid=%b expected 0 00 0",
               state_led, A, operands_valid);
    end
    sw = 6'h2A;
    for (int i = 0; i < 10; i++) begin
      load_btn = ~load_btn;
      wait_cycles(1);
    end
    load_btn = 1'b0;
    wait_cycles(10);
    checks++;
    if (state_led !== 2'd0 || A !== 6'h00) begin
      errors++;
      $display("FAIL glitch_ignored: got state=%0d A=%h expected state=0 A=00", state_led, A);
    end
  endtask

  // A long hold gives exactly one capture.
  task automatic test_hold();
    sw       = 6'h15;
    load_btn = 1'b1;
    wait_cycles(50);
    checks++;
    if (state_led !== 2'd1 || A !== 6'h15) begin
      errors++;
      $display("FAIL hold_one_capture: got state=%0d A=%h expected state=1 A=15", state_led, A);
    end
    load_btn = 1'b0;
    wait_cycles(10);
    checks++;
    if (state_led !== 2'd1 || B !== 6'h00) begin
      errors++;
      $display("FAIL hold_release: got state=%0d B=%h expected state=1 B=00", state_led, B);
    end
  endtask

  // A load pulse in READY drops valid one cycle later and keeps the operands.
  task automatic test_ready_reload();
    press_clear();
    sw    = 6'd5;
    press_load();
    sw    = 6'd7;
    press_load();
    op_sw = 3'd1;
    press_load();
    checks++;
    if (operands_valid !== 1'b1 || state_led !== 2'd3) begin
      errors++;
      $display("FAIL reload_ready: got valid=%b state=%0d expected 1 3", operands_valid, state_led);
    end
    load_btn = 1'b1;
    wait_cycles(6);
    checks++;
    if (operands_valid !== 1'b1 || state_led !== 2'd3) begin
      errors++;
      $display("FAIL reload_pulse_cycle: got valid=%b state=%0d expected 1 3", operands_valid, state_led);
    end
    wait_cycles(1);
    checks++;
    if (operands_valid !== 1'b0 || state_led !== 2'd0 || A !== 6'd5 || B !== 6'd7 || op !== 3'd1) begin
      errors++;
      $display("FAIL reload_after: got valid=%b state=%0d A=%h B=%h op=%0d expected 0 0 05 07 1",
               operands_valid, state_led, A, B, op);
    end
    load_btn = 1'b0;
    wait_cycles(8);
  endtask

  // Clear beats load when the two pulses coincide.
  task automatic test_clear_wins();
    press_clear();
    sw    = 6'h0A;
    press_load();
    sw    = 6'h0B;
    press_load();
    op_sw = 3'd6;
    checks++;
    if (state_led !== 2'd2 || A !== 6'h0A || B !== 6'h0B) begin
      errors++;
      $display("FAIL clear_setup: got state=%0d A=%h B=%h expected 2 0a 0b", state_led, A, B);
    end
    load_btn  = 1'b1;
    clear_btn = 1'b1;
    wait_cycles(8);
    load_btn  = 1'b0;
    clear_btn = 1'b0;
    wait_cycles(8);
    checks++;
    if (state_led !== 2'd0 || A !== 6'h00 || B !== 6'h00 || op !== 3'd0 || operands_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: got state=%0d A=%h B=%h op=%0d valid=%b expected all 0",
               state_led, A, B, op, operands_valid);
    end
  endtask

  // Reset mid-entry acts at once, and a fresh entry then works normally.
  task automatic test_async_reset();
    sw = 6'h20;
    press_load();
    checks++;
    if (state_led !== 2'd1 || A !== 6'h20) begin
      errors++;
      $display("FAIL arst_setup: got state=%0d A=%h expected 1 20", state_led, A);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({A, B, op, operands_valid, state_led} !== 18'd0) begin
      errors++;
      $display("FAIL arst_immediate: got A=%h B=%h op=%0d valid=%b state=%0d expected all 0",
               A, B, op, operands_valid, state_led);
    end
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(1);
    sw    = 6'h3F;
    press_load();
    sw    = 6'h01;
    press_load();
    op_sw = 3'd7;
    press_load();
    checks++;
    if (A !== 6'h3F || B !== 6'h01 || op !== 3'd7 || operands_valid !== 1'b1 || state_led !== 2'd3) begin
      errors++;
      $display("FAIL arst_resequence: got A=%h B=%h op=%0d valid=%b state=%0d expected 3f 01 7 1 3",
               A, B, op, operands_valid, state_led);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_glitch();
    test_hold();
    test_ready_reload();
    test_clear_wins();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
